// File: rtl/if_stage_pkg.sv
// Shared types for the instruction fetch stage: bus words, IF->ID payload and FSM states.
package if_stage_pkg;

    typedef logic [31:0] u32_t;

    typedef struct packed {
        u32_t ir;
        u32_t ia_plus_4;
    } id_params_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_KILL
    } if_state_e;

    localparam u32_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

    function automatic u32_t word_align(input u32_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction bus, EX redirect and IF->ID handshake.
interface if_stage_if;
    import if_stage_pkg::*;

    logic       ibus_req;
    u32_t       ibus_addr;
    logic       ibus_ack;
    u32_t       ibus_rdata;
    logic       br_taken;
    u32_t       br_target;
    logic       id_valid;
    logic       id_ready;
    id_params_t id_params;

    modport master (
        output ibus_req, ibus_addr, id_valid, id_params,
        input  ibus_ack, ibus_rdata, br_taken, br_target, id_ready
    );

    modport slave (
        input  ibus_req, ibus_addr, id_valid, id_params,
        output ibus_ack, ibus_rdata, br_taken, br_target, id_ready
    );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// Prefetch FIFO between the instruction bus and ID; power-of-two depth, synchronous flush.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  id_params_t               wdata,
    output id_params_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    id_params_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus and feeds ID through a prefetch FIFO.
//   state  | meaning
//   S_IDLE | no request outstanding; waits for FIFO space
//   S_REQ  | request outstanding, response will be kept
//   S_KILL | request outstanding from before a redirect, response will be dropped
module if_stage
    import if_stage_pkg::*;
#(
    parameter u32_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int   FIFO_DEPTH   = 2
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = FIFO_DEPTH[CW-1:0];

    if_state_e     state;
    u32_t          pc;
    u32_t          addr;
    u32_t          addr_plus_4;
    u32_t          target;
    logic          req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    id_params_t    head;

    assign addr_plus_4 = addr + 32'd4;
    assign target      = word_align(bus.br_target);
    assign pop         = !empty && bus.id_ready;
    assign push        = (state == S_REQ) && bus.ibus_ack && !bus.br_taken;
    assign count_after = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    assign bus.ibus_req  = req;
    assign bus.ibus_addr = addr;
    assign bus.id_valid  = !empty;
    assign bus.id_params = empty ? '0 : head;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.br_taken),
        .wdata ('{ir: bus.ibus_rdata, ia_plus_4: addr_plus_4}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            req   <= 1'b0;
            addr  <= RESET_VECTOR;
            pc    <= RESET_VECTOR;
        end else if (bus.br_taken) begin
            pc <= target;
            // An unanswered request must complete before the target can be issued.
            if (state != S_IDLE && !bus.ibus_ack) begin
                state <= S_KILL;
            end else begin
                state <= S_REQ;
                req   <= 1'b1;
                addr  <= target;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (!full || pop) begin
                        state <= S_REQ;
                        req   <= 1'b1;
                        addr  <= pc;
                    end
                end
                S_REQ: begin
                    if (bus.ibus_ack) begin
                        pc <= addr_plus_4;
                        if (count_after < DEPTH_C) begin
                            addr <= addr_plus_4;
                        end else begin
                            state <= S_IDLE;
                            req   <= 1'b0;
                        end
                    end
                end
                S_KILL: begin
                    if (bus.ibus_ack) begin
                        state <= S_REQ;
                        addr  <= pc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_without_req: assert (!(bus.ibus_ack && !req))
                else $error("ibus_ack received with no request outstanding");
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall, redirects, PC wrap and mid-transaction reset.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   lat = 0;
    int   wcnt;
    int   vectors = 0;
    int   miscompares = 0;

    if_stage_if bus ();
    if_stage_if bus2 ();

    if_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    if_stage #(
        .RESET_VECTOR (32'hFFFF_FFFC),
        .FIFO_DEPTH   (2)
    ) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    function automatic u32_t memw(input u32_t a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack once a request has waited 'lat' cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus.ibus_req && !bus.ibus_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    assign bus.ibus_ack    = bus.ibus_req && (wcnt == lat);
    assign bus.ibus_rdata  = memw(bus.ibus_addr);
    assign bus2.ibus_ack   = bus2.ibus_req;
    assign bus2.ibus_rdata = memw(bus2.ibus_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.id_ready = 1'b1;
        lat = 0;
        rst = 1'b1;
        repeat (2) tick();
        if (bus.ibus_req !== 1'b0) begin
            $display("FAIL reset_req got %b want 0", bus.ibus_req); miscompares++;
        end
        vectors++;
        if (bus.ibus_addr !== 32'h0) begin
            $display("FAIL reset_addr got %h want 00000000", bus.ibus_addr); miscompares++;
        end
        vectors++;
        if (bus.id_valid !== 1'b0) begin
            $display("FAIL reset_valid got %b want 0", bus.id_valid); miscompares++;
        end
        vectors++;
        if (bus.id_params !== 64'h0) begin
            $display("FAIL reset_params got %h want 0", bus.id_params); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_stream();
        bus.id_ready = 1'b1;
        lat = 0;
        do_reset();
        tick();
        if (bus.ibus_req !== 1'b1 || bus.ibus_addr !== 32'h0) begin
            $display("FAIL stream_first_req got req=%b addr=%h want req=1 addr=00000000",
                     bus.ibus_req, bus.ibus_addr); miscompares++;
        end
        vectors++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.id_valid !== 1'b1) begin
                $display("FAIL stream_valid[%0d] got %b want 1", i, bus.id_valid); miscompares++;
            end
            vectors++;
            if (bus.id_params.ir !== memw(32'(4 * i))) begin
                $display("FAIL stream_ir[%0d] got %h want %h", i, bus.id_params.ir, memw(32'(4 * i)));
                miscompares++;
            end
            vectors++;
            if (bus.id_params.ia_plus_4 !== 32'(4 * i + 4)) begin
                $display("FAIL stream_ia4[%0d] got %h want %h", i, bus.id_params.ia_plus_4, 32'(4 * i + 4));
                miscompares++;
            end
            vectors++;
            if (bus.ibus_addr !== 32'(4 * i + 4) || bus.ibus_req !== 1'b1) begin
                $display("FAIL stream_addr[%0d] got req=%b addr=%h want req=1 addr=%h",
                         i, bus.ibus_req, bus.ibus_addr, 32'(4 * i + 4)); miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_stall();
        bus.id_ready = 1'b0;
        lat = 0;
        do_reset();
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            if (bus.ibus_req !== 1'b0) begin
                $display("FAIL stall_req[%0d] got %b want 0", k, bus.ibus_req); miscompares++;
            end
            vectors++;
            if (bus.id_valid !== 1'b1 || bus.id_params.ir !== memw(32'h0) ||
                bus.id_params.ia_plus_4 !== 32'h4) begin
                $display("FAIL stall_head[%0d] got v=%b ir=%h ia4=%h want v=1 ir=%h ia4=00000004",
                         k, bus.id_valid, bus.id_params.ir, bus.id_params.ia_plus_4, memw(32'h0));
                miscompares++;
            end
            vectors++;
            tick();
        end
        bus.id_ready = 1'b1;
        tick();
        if (bus.ibus_req !== 1'b1 || bus.ibus_addr !== 32'h8) begin
            $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=00000008",
                     bus.ibus_req, bus.ibus_addr); miscompares++;
        end
        vectors++;
        if (bus.id_params.ir !== memw(32'h4) || bus.id_params.ia_plus_4 !== 32'h8) begin
            $display("FAIL stall_second got ir=%h ia4=%h want ir=%h ia4=00000008",
                     bus.id_params.ir, bus.id_params.ia_plus_4, memw(32'h4)); miscompares++;
        end
        vectors++;
        tick();
        if (bus.id_params.ir !== memw(32'h8) || bus.id_params.ia_plus_4 !== 32'hC) begin
            $display("FAIL stall_third got ir=%h ia4=%h want ir=%h ia4=0000000c",
                     bus.id_params.ir, bus.id_params.ia_plus_4, memw(32'h8)); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_branch_waiting();
        bus.id_ready = 1'b1;
        lat = 2;
        do_reset();
        tick();
        bus.br_taken = 1'b1;
        bus.br_target = 32'h103;
        tick();
        bus.br_taken = 1'b0;
        if (bus.ibus_req !== 1'b1 || bus.ibus_addr !== 32'h0 || bus.id_valid !== 1'b0) begin
            $display("FAIL br_kill got req=%b addr=%h v=%b want req=1 addr=00000000 v=0",
                     bus.ibus_req, bus.ibus_addr, bus.id_valid); miscompares++;
        end
        vectors++;
        repeat (2) tick();
        if (bus.ibus_req !== 1'b1 || bus.ibus_addr !== 32'h100) begin
            $display("FAIL br_target_addr got req=%b addr=%h want req=1 addr=00000100",
                     bus.ibus_req, bus.ibus_addr); miscompares++;
        end
        vectors++;
        for (int k = 0; k < 3; k++) begin
            if (bus.id_valid !== 1'b0) begin
                $display("FAIL br_no_stale[%0d] got v=%b ir=%h want v=0",
                         k, bus.id_valid, bus.id_params.ir); miscompares++;
            end
            vectors++;
            tick();
        end
        if (bus.id_valid !== 1'b1 || bus.id_params.ia_plus_4 !== 32'h104 ||
            bus.id_params.ir !== memw(32'h100)) begin
            $display("FAIL br_first_entry got v=%b ir=%h ia4=%h want v=1 ir=%h ia4=00000104",
                     bus.id_valid, bus.id_params.ir, bus.id_params.ia_plus_4, memw(32'h100));
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_branch_with_ack();
        bus.id_ready = 1'b0;
        lat = 0;
        do_reset();
        repeat (2) tick();
        bus.br_taken = 1'b1;
        bus.br_target = 32'h202;
        tick();
        bus.br_taken = 1'b0;
        if (bus.id_valid !== 1'b0 || bus.id_params !== 64'h0) begin
            $display("FAIL br_ack_flush got v=%b params=%h want v=0 params=0",
                     bus.id_valid, bus.id_params); miscompares++;
        end
        vectors++;
        if (bus.ibus_req !== 1'b1 || bus.ibus_addr !== 32'h200) begin
            $display("FAIL br_ack_addr got req=%b addr=%h want req=1 addr=00000200",
                     bus.ibus_req, bus.ibus_addr); miscompares++;
        end
        vectors++;
        tick();
        if (bus.id_valid !== 1'b1 || bus.id_params.ir !== memw(32'h200) ||
            bus.id_params.ia_plus_4 !== 32'h204) begin
            $display("FAIL br_ack_entry got v=%b ir=%h ia4=%h want v=1 ir=%h ia4=00000204",
                     bus.id_valid, bus.id_params.ir, bus.id_params.ia_plus_4, memw(32'h200));
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_wrap();
        bus.id_ready = 1'b1;
        do_reset();
        tick();
        if (bus2.ibus_req !== 1'b1 || bus2.ibus_addr !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_first_addr got req=%b addr=%h want req=1 addr=fffffffc",
                     bus2.ibus_req, bus2.ibus_addr); miscompares++;
        end
        vectors++;
        tick();
        if (bus2.id_valid !== 1'b1 || bus2.id_params.ia_plus_4 !== 32'h0 ||
            bus2.id_params.ir !== memw(32'hFFFF_FFFC)) begin
            $display("FAIL wrap_entry got v=%b ir=%h ia4=%h want v=1 ir=%h ia4=00000000",
                     bus2.id_valid, bus2.id_params.ir, bus2.id_params.ia_plus_4, memw(32'hFFFF_FFFC));
            miscompares++;
        end
        vectors++;
        if (bus2.ibus_addr !== 32'h0) begin
            $display("FAIL wrap_next_addr got %h want 00000000", bus2.ibus_addr); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset_mid();
        bus.id_ready = 1'b1;
        lat = 2;
        do_reset();
        repeat (4) tick();
        if (bus.id_valid !== 1'b1 || bus.ibus_addr !== 32'h4 || bus.ibus_req !== 1'b1) begin
            $display("FAIL rstmid_pre got v=%b req=%b addr=%h want v=1 req=1 addr=00000004",
                     bus.id_valid, bus.ibus_req, bus.ibus_addr); miscompares++;
        end
        vectors++;
        rst = 1'b1;
        #1;
        if (bus.ibus_req !== 1'b0 || bus.ibus_addr !== 32'h0 || bus.id_valid !== 1'b0 ||
            bus.id_params !== 64'h0) begin
            $display("FAIL rstmid_outputs got req=%b addr=%h v=%b params=%h want req=0 addr=0 v=0 params=0",
                     bus.ibus_req, bus.ibus_addr, bus.id_valid, bus.id_params); miscompares++;
        end
        vectors++;
        tick();
        rst = 1'b0;
        tick();
        if (bus.ibus_req !== 1'b1 || bus.ibus_addr !== 32'h0) begin
            $display("FAIL rstmid_restart got req=%b addr=%h want req=1 addr=00000000",
                     bus.ibus_req, bus.ibus_addr); miscompares++;
        end
        vectors++;
    endtask

    initial begin
        bus.id_ready   = 1'b1;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        bus2.id_ready  = 1'b1;
        bus2.br_taken  = 1'b0;
        bus2.br_target = '0;
        test_reset();
        test_stream();
        test_stall();
        test_branch_waiting();
        test_branch_with_ack();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
